mc_alu: RTL
===========

MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 Parameter WIDTH, default 8: datapath width in bits; legal values are 8, 16 and 32.
REQ-002 Parameter SHAMT_W, default $clog2(WIDTH): shift-amount width, derived and never overridden.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RESET  input  1  reset, asynchronous and active-low.
REQ-005 START  input  1  request; sampled only when BUSY=0.
REQ-006 SELECT  input  4  opcode, captured with START.
REQ-007 DATA1  input  WIDTH  operand A, unsigned except under SRA.
REQ-008 DATA2  input  WIDTH  operand B, two's complement; DATA2[SHAMT_W-1:0] is the shift amount.
REQ-009 RESULT  output  WIDTH  registered result, held until the next completion.
REQ-010 ZERO  output  1  registered; 1 iff the completed RESULT == 0.
REQ-011 BUSY  output  1  operation in progress.
REQ-012 DONE  output  1  one-cycle completion pulse; RESULT and ZERO are valid in that cycle.

Function
REQ-013 Opcodes SHALL be: 0 FWD (DATA2), 1 ADD, 2 AND, 3 OR, 4 SUB (DATA1-DATA2), 5 ROR, 6 SLL, 7 SRL, 8 SRA, 9 MUL; 10-15 undefined.
REQ-014 States SHALL be IDLE, EXEC and FIN; START with BUSY=0 latches SELECT, DATA1 and DATA2 and enters EXEC.
REQ-015 FWD, ADD, AND, OR, SUB and undefined opcodes SHALL complete in EXEC in 1 cycle: DONE is asserted on the edge after START (latency 1).
REQ-016 ADD and SUB SHALL wrap modulo 2^WIDTH; no carry or overflow output exists.
REQ-017 ROR, SLL, SRL and SRA SHALL shift 1 bit per cycle; latency = shamt+1 cycles.
REQ-018 Shift amount 0 SHALL return DATA1 unchanged with latency 1.
REQ-019 SRA SHALL replicate DATA1[WIDTH-1]; SLL and SRL SHALL fill with zeros; ROR SHALL rotate right.
REQ-020 MUL SHALL use iterative shift-add and return the low WIDTH bits of the product; latency WIDTH+1.
REQ-021 Undefined opcodes SHALL give RESULT=0, ZERO=1.
REQ-022 BUSY SHALL be 1 from the edge after START until completion.
REQ-023 BUSY SHALL be 0 in the DONE cycle, so a START in that cycle is accepted back-to-back.
REQ-024 START while BUSY=1 SHALL be ignored; operands are not re-sampled.
REQ-025 FIN SHALL last exactly one cycle: return to IDLE, or enter EXEC if START is asserted.
REQ-026 Operand changes after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-027 RESET=0 SHALL immediately force IDLE and RESULT=0, ZERO=0, BUSY=0, DONE=0.
REQ-028 A RESET assertion mid-operation SHALL abort the operation with no DONE pulse.
REQ-029 The first START SHALL be accepted on the first rising edge after RESET deasserts.

Configuration
REQ-030 Macro MC_ALU_MUL_EN defined: opcode 9 behaves per REQ-020.
REQ-031 MC_ALU_MUL_EN undefined: the multiplier is not synthesised and opcode 9 is treated as undefined per REQ-015 and REQ-021.

Structure
REQ-032 Package alu_pkg SHALL hold the opcode enum (alu_op_t), the state enum and the opcode constants, shared with the decoder.
REQ-033 Sub-module mc_alu_shift SHALL implement the 1-bit-per-cycle ROR/SLL/SRL/SRA step and its remaining-count counter.
REQ-034 mc_alu SHALL hold the FSM, the single-cycle ops and the MUL loop.

Verification (WIDTH=8)
REQ-035 ADD 8'h7F+8'h01 -> DONE 1 cycle after START, RESULT=8'h80, ZERO=0; ADD 8'hFF+8'h01 -> RESULT=8'h00, ZERO=1.
REQ-036 SRA DATA1=8'h90, DATA2=3 -> BUSY high 3 cycles, DONE on cycle 4, RESULT=8'hF2.
REQ-037 ROR DATA1=8'h81, DATA2=0 -> RESULT=8'h81, latency 1; ROR DATA1=8'h81, DATA2=1 -> RESULT=8'hC0, latency 2.
REQ-038 MUL 8'h0C*8'h0B with macro defined -> RESULT=8'h84 at latency 9; without macro -> RESULT=8'h00, ZERO=1 at latency 1.
REQ-039 SLL shamt 5 with RESET pulled low at cycle 2 -> outputs 0 at once, no DONE; START after release is accepted.
REQ-040 START held high through SLL shamt 2 -> ignored while BUSY; second op accepted in the DONE cycle, completing back-to-back.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcode and state definitions shared by mc_alu and its serial shift unit.
package alu_pkg;

    localparam int OPCODE_W = 4;

    typedef enum logic [OPCODE_W-1:0] {
        OP_FWD = 4'd0,
        OP_ADD = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_SUB = 4'd4,
        OP_ROR = 4'd5,
        OP_SLL = 4'd6,
        OP_SRL = 4'd7,
        OP_SRA = 4'd8,
        OP_MUL = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_FIN  = 2'd2
    } alu_state_t;

    // Opcodes are carried as raw 4-bit codes so that undefined values 10-15 stay representable.
    function automatic logic is_shift(input logic [OPCODE_W-1:0] op);
        return (op == OP_ROR) || (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/mc_alu_shift.sv
// Serial shift unit for mc_alu: moves one bit position per cycle for ROR/SLL/SRL/SRA
// and tracks how many positions remain.
module mc_alu_shift import alu_pkg::*; #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                step,
    input  logic [OPCODE_W-1:0] op,
    input  logic [WIDTH-1:0]    data,
    input  logic [SHAMT_W-1:0]  shamt,
    output logic [WIDTH-1:0]    value,
    output logic                last
);

    logic [WIDTH-1:0]   value_reg;
    logic [WIDTH-1:0]   value_next;
    logic [SHAMT_W-1:0] count_reg;

    always_comb begin
        value_next = value_reg;
        case (op)
            OP_ROR:  value_next = {value_reg[0], value_reg[WIDTH-1:1]};
            OP_SLL:  value_next = {value_reg[WIDTH-2:0], 1'b0};
            OP_SRL:  value_next = {1'b0, value_reg[WIDTH-1:1]};
            OP_SRA:  value_next = {value_reg[WIDTH-1], value_reg[WIDTH-1:1]};
            default: value_next = value_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_reg <= '0;
            count_reg <= '0;
        end else if (load) begin
            value_reg <= data;
            count_reg <= shamt;
        end else if (step && (count_reg != '0)) begin
            value_reg <= value_next;
            count_reg <= count_reg - SHAMT_W'(1);
        end
    end

    assign value = value_reg;
    assign last  = (count_reg == '0);

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU: IDLE/EXEC/FIN control, single-cycle ops, serial shifts and shift-add multiply.
// Define MC_ALU_MUL_EN to build the opcode-9 multiplier; otherwise opcode 9 behaves as undefined.
module mc_alu import alu_pkg::*; #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                START,
    input  logic [OPCODE_W-1:0] SELECT,
    input  logic [WIDTH-1:0]    DATA1,
    input  logic [WIDTH-1:0]    DATA2,
    output logic [WIDTH-1:0]    RESULT,
    output logic                ZERO,
    output logic                BUSY,
    output logic                DONE
);

    alu_state_t          state_reg;
    logic [OPCODE_W-1:0] op_reg;
    logic [WIDTH-1:0]    a_reg;
    logic [WIDTH-1:0]    b_reg;
    logic [WIDTH-1:0]    result_reg;
    logic                zero_reg;
    logic                busy_reg;
    logic                done_reg;

    logic                accept;
    logic [WIDTH-1:0]    shift_value;
    logic                shift_last;
    logic [WIDTH-1:0]    single_value;
    logic                exec_done;
    logic [WIDTH-1:0]    exec_value;

`ifdef MC_ALU_MUL_EN
    localparam logic [SHAMT_W:0] MUL_ITERS = (SHAMT_W + 1)'(WIDTH);
    logic [SHAMT_W:0] mul_count_reg;
    logic [WIDTH-1:0] mul_acc_reg;
`endif

    // BUSY is low exactly in IDLE and FIN, the two states that may take a new request.
    assign accept = START && !busy_reg;

    mc_alu_shift #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shift (
        .clk   (CLK),
        .rst_n (RESET),
        .load  (accept),
        .step  (state_reg == ST_EXEC),
        .op    (op_reg),
        .data  (DATA1),
        .shamt (DATA2[SHAMT_W-1:0]),
        .value (shift_value),
        .last  (shift_last)
    );

    always_comb begin
        single_value = '0;
        case (op_reg)
            OP_FWD:  single_value = b_reg;
            OP_ADD:  single_value = a_reg + b_reg;
            OP_AND:  single_value = a_reg & b_reg;
            OP_OR:   single_value = a_reg | b_reg;
            OP_SUB:  single_value = a_reg - b_reg;
            default: single_value = '0;
        endcase
    end

    always_comb begin
        exec_done  = 1'b1;
        exec_value = single_value;
        if (is_shift(op_reg)) begin
            exec_done  = shift_last;
            exec_value = shift_value;
        end
`ifdef MC_ALU_MUL_EN
        else if (op_reg == OP_MUL) begin
            exec_done  = (mul_count_reg == '0);
            exec_value = mul_acc_reg;
        end
`endif
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg     <= ST_IDLE;
            op_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
`ifdef MC_ALU_MUL_EN
            mul_count_reg <= '0;
            mul_acc_reg   <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_FIN: begin
                    if (START) begin
                        state_reg     <= ST_EXEC;
                        busy_reg      <= 1'b1;
                        op_reg        <= SELECT;
                        a_reg         <= DATA1;
                        b_reg         <= DATA2;
`ifdef MC_ALU_MUL_EN
                        mul_count_reg <= MUL_ITERS;
                        mul_acc_reg   <= '0;
`endif
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (exec_done) begin
                        state_reg  <= ST_FIN;
                        busy_reg   <= 1'b0;
                        done_reg   <= 1'b1;
                        result_reg <= exec_value;
                        zero_reg   <= (exec_value == '0);
                    end
`ifdef MC_ALU_MUL_EN
                    // One shift-add step per cycle; the operand registers are consumed in place.
                    else if (op_reg == OP_MUL) begin
                        if (b_reg[0]) begin
                            mul_acc_reg <= mul_acc_reg + a_reg;
                        end
                        a_reg         <= a_reg << 1;
                        b_reg         <= b_reg >> 1;
                        mul_count_reg <= mul_count_reg - (SHAMT_W + 1)'(1);
                    end
`endif
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign RESULT = result_reg;
    assign ZERO   = zero_reg;
    assign BUSY   = busy_reg;
    assign DONE   = done_reg;

endmodule
